operand_forward_stage: RTL

- Decode/execute boundary register, directly downstream of the register-state scoreboard.
- Consumes the per-operand 3-bit forward select and 2-bit source type. Picks each operand from the register file or one of the in-flight pipeline results, then registers the operands with the issue fields into the EX stage.
- Handles issue gating, downstream hold, flush bubbles, and a one-entry "written" bypass latch covering the register-file write/read turnaround.

---
 rtl/operand_forward_stage_pkg.sv | 28 ++
 rtl/operand_forward_stage_fwd_operand_mux.sv | 43 ++++
 rtl/operand_forward_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/operand_forward_stage_pkg.sv
// Shared pipeline definitions: forward-select codes, producer-type codes and
// the register-state codes used by the scoreboard feeding this stage.
package operand_forward_stage_pkg;

  localparam logic [2:0] SEL_RF      = 3'd0;
  localparam logic [2:0] SEL_EX      = 3'd1;
  localparam logic [2:0] SEL_EX2     = 3'd2;
  localparam logic [2:0] SEL_MEM1    = 3'd3;
  localparam logic [2:0] SEL_MEM2    = 3'd4;
  localparam logic [2:0] SEL_MEM3    = 3'd5;
  localparam logic [2:0] SEL_WB      = 3'd6;
  localparam logic [2:0] SEL_WRITTEN = 3'd7;

  localparam logic [1:0] TYPE_DIRECT = 2'b00;
  localparam logic [1:0] TYPE_ALU    = 2'b01;
  localparam logic [1:0] TYPE_LD     = 2'b10;

  // Per-register producer state tracked by the upstream scoreboard.
  typedef enum logic [1:0] {
    REG_READY    = 2'b00,
    REG_PEND_ALU = 2'b01,
    REG_PEND_LD  = 2'b10,
    REG_PEND_MUL = 2'b11
  } reg_state_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/operand_forward_stage_fwd_operand_mux.sv
// fwd_operand_mux: combinational 8-way operand source select. MEM3 and WB
// carry both an ALU result and load data; the producer type picks between
// them (reserved type 11 behaves as ALU). Other sources ignore the type.
module fwd_operand_mux
  import operand_forward_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        sel,
  input  logic [1:0]        src_type,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] ex2_data,
  input  logic [DATA_W-1:0] mem1_data,
  input  logic [DATA_W-1:0] mem2_data,
  input  logic [DATA_W-1:0] mem3_alu,
  input  logic [DATA_W-1:0] mem3_ld,
  input  logic [DATA_W-1:0] wb_alu,
  input  logic [DATA_W-1:0] wb_ld,
  input  logic [DATA_W-1:0] written_data,
  output logic [DATA_W-1:0] operand
);

  logic is_ld;
  assign is_ld = (src_type == TYPE_LD);

  // Source select; type only matters for the two split stages.
  always_comb begin
    operand = rf_data;
    case (sel)
      SEL_RF:      operand = rf_data;
      SEL_EX:      operand = ex_data;
      SEL_EX2:     operand = ex2_data;
      SEL_MEM1:    operand = mem1_data;
      SEL_MEM2:    operand = mem2_data;
      SEL_MEM3:    operand = is_ld ? mem3_ld : mem3_alu;
      SEL_WB:      operand = is_ld ? wb_ld : wb_alu;
      SEL_WRITTEN: operand = written_data;
      default:     operand = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_forward_stage.sv
// operand_forward_stage: decode/execute boundary register. Selects both
// operands from the register file or in-flight results and registers them
// with PC/control into EX. A one-entry latch of the last register-file write
// covers the write/read turnaround.
// Optional build macro PERF_STALL_CNT_EN adds a saturating issue-stall
// counter (STALL_CNT) with a synchronous clear (STALL_CNT_CLR).
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ISSUE_VALID,
  input  logic              OPS_READY,
  input  logic              HOLD,
  input  logic              FLUSH,
  input  logic [2:0]        MUX1_SELECT,
  input  logic [2:0]        MUX2_SELECT,
  input  logic [1:0]        RS1_TYPE,
  input  logic [1:0]        RS2_TYPE,
  input  logic [DATA_W-1:0] RF_RS1_DATA,
  input  logic [DATA_W-1:0] RF_RS2_DATA,
  input  logic [DATA_W-1:0] FWD_EX_DATA,
  input  logic [DATA_W-1:0] FWD_EX2_DATA,
  input  logic [DATA_W-1:0] FWD_MEM1_DATA,
  input  logic [DATA_W-1:0] FWD_MEM2_DATA,
  input  logic [DATA_W-1:0] FWD_MEM3_ALU,
  input  logic [DATA_W-1:0] FWD_MEM3_LD,
  input  logic [DATA_W-1:0] FWD_WB_ALU,
  input  logic [DATA_W-1:0] FWD_WB_LD,
  input  logic              WB_WE,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic [PC_W-1:0]   PC_IN,
  input  logic [CTRL_W-1:0] CTRL_IN,
  output logic              ISSUE_ACCEPT,
  output logic              EX_VALID,
  output logic [DATA_W-1:0] EX_RS1_DATA,
  output logic [DATA_W-1:0] EX_RS2_DATA,
  output logic [PC_W-1:0]   EX_PC,
  output logic [CTRL_W-1:0] EX_CTRL
`ifdef PERF_STALL_CNT_EN
  ,
  input  logic                   STALL_CNT_CLR,
  output logic [STALL_CNT_W-1:0] STALL_CNT
`endif
);

  logic [DATA_W-1:0] written_q;
  logic [DATA_W-1:0] rs1_sel;
  logic [DATA_W-1:0] rs2_sel;

  assign ISSUE_ACCEPT = ISSUE_VALID & OPS_READY & ~HOLD & ~FLUSH;

  fwd_operand_mux #(.DATA_W(DATA_W)) u_rs1_mux (
    .sel          (MUX1_SELECT),
    .src_type     (RS1_TYPE),
    .rf_data      (RF_RS1_DATA),
    .ex_data      (FWD_EX_DATA),
    .ex2_data     (FWD_EX2_DATA),
    .mem1_data    (FWD_MEM1_DATA),
    .mem2_data    (FWD_MEM2_DATA),
    .mem3_alu     (FWD_MEM3_ALU),
    .mem3_ld      (FWD_MEM3_LD),
    .wb_alu       (FWD_WB_ALU),
    .wb_ld        (FWD_WB_LD),
    .written_data (written_q),
    .operand      (rs1_sel)
  );

  fwd_operand_mux #(.DATA_W(DATA_W)) u_rs2_mux (
    .sel          (MUX2_SELECT),
    .src_type     (RS2_TYPE),
    .rf_data      (RF_RS2_DATA),
    .ex_data      (FWD_EX_DATA),
    .ex2_data     (FWD_EX2_DATA),
    .mem1_data    (FWD_MEM1_DATA),
    .mem2_data    (FWD_MEM2_DATA),
    .mem3_alu     (FWD_MEM3_ALU),
    .mem3_ld      (FWD_MEM3_LD),
    .wb_alu       (FWD_WB_ALU),
    .wb_ld        (FWD_WB_LD),
    .written_data (written_q),
    .operand      (rs2_sel)
  );

  // Capture every register-file write, independent of pipeline stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      written_q <= '0;
    end else if (WB_WE) begin
      written_q <= WB_DATA;
    end
  end

  // EX register: reset > flush > hold > accept > bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      EX_VALID    <= 1'b0;
      EX_RS1_DATA <= '0;
      EX_RS2_DATA <= '0;
      EX_PC       <= '0;
      EX_CTRL     <= '0;
    end else if (FLUSH) begin
      EX_VALID <= 1'b0;
    end else if (HOLD) begin
      EX_VALID <= EX_VALID;
    end else if (ISSUE_ACCEPT) begin
      EX_VALID    <= 1'b1;
      EX_RS1_DATA <= rs1_sel;
      EX_RS2_DATA <= rs2_sel;
      EX_PC       <= PC_IN;
      EX_CTRL     <= CTRL_IN;
    end else begin
      EX_VALID <= 1'b0;
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = ISSUE_VALID & ~ISSUE_ACCEPT & ~FLUSH;

  // Saturating count of cycles where decode had an instruction but could not issue.
  always_ff @(posedge CLK) begin
    if (RST || STALL_CNT_CLR) begin
      STALL_CNT <= '0;
    end else if (stall_evt && (STALL_CNT != {STALL_CNT_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end
`endif

endmodule
